// File: rtl/i2s_receiver.sv
// i2s_receiver: captures 16-bit left/right I2S samples from an asynchronous
// bit clock and presents them as one 32-bit word {left, right}.
//
// Optional feature macro: I2S_RECEIVER_OVERRUN_COUNT_EN
//   defined   -> overrun_count is a saturating 8-bit count of overrun pulses
//   undefined -> overrun_count is tied to 0 and no counter register exists
//
// Output handshake: out_valid=1 means out_data holds a word nobody has taken
// yet; the word is consumed on a rising in_clk edge where out_valid=1 and
// out_ready=1. A new word that arrives while the old one is still unconsumed
// replaces it and raises overrun for one cycle; a new word arriving on the
// consuming edge simply takes the old one's place.
module i2s_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        in_clk,
    input  logic        reset,
    input  logic        rx_enable,
    input  logic        bck,
    input  logic        lrck,
    input  logic        sdin,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun,
    output logic        framing_err,
    output logic [7:0]  overrun_count
);

    // Synchronizer chains; the last stage is the only copy the logic sees.
    logic [SYNC_STAGES-1:0] bck_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] sdin_sync;
    logic                   bck_s;
    logic                   lrck_s;
    logic                   sdin_s;
    logic                   bck_prev;
    logic                   bck_rise;

    // Capture state.
    logic        lr_prev;        // lrck seen at the previous bck rise
    logic        lr_prev_valid;  // lr_prev holds a real sample
    logic        locked;         // an lrck change has been observed
    logic        channel;        // 0 = left, 1 = right
    logic [4:0]  bit_cnt;        // data bits captured in this channel (0..16)
    logic        left_ok;        // a full left sample is waiting for its right
    logic [15:0] left_sr;
    logic [15:0] right_sr;

    logic        lr_prev_n;
    logic        lr_prev_valid_n;
    logic        locked_n;
    logic        channel_n;
    logic [4:0]  bit_cnt_n;
    logic        left_ok_n;
    logic [15:0] left_sr_n;
    logic [15:0] right_sr_n;
    logic        word_load;
    logic        fe_set;
    logic        overrun_set;
    logic [31:0] word;

    // Bring the three I2S lines into the in_clk domain.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            bck_sync  <= '0;
            lrck_sync <= '0;
            sdin_sync <= '0;
            bck_prev  <= 1'b0;
        end else begin
            bck_sync  <= {bck_sync[SYNC_STAGES-2:0], bck};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
            bck_prev  <= bck_s;
        end
    end

    assign bck_s    = bck_sync[SYNC_STAGES-1];
    assign lrck_s   = lrck_sync[SYNC_STAGES-1];
    assign sdin_s   = sdin_sync[SYNC_STAGES-1];
    assign bck_rise = bck_s & ~bck_prev;

    // Next capture state: an lrck change closes the old channel (its bit is
    // the old channel's last, one-bit I2S delay), then 16 bits shift in and
    // any padding after that is ignored.
    always_comb begin
        lr_prev_n       = lr_prev;
        lr_prev_valid_n = lr_prev_valid;
        locked_n        = locked;
        channel_n       = channel;
        bit_cnt_n       = bit_cnt;
        left_ok_n       = left_ok;
        left_sr_n       = left_sr;
        right_sr_n      = right_sr;
        word_load       = 1'b0;
        fe_set          = 1'b0;

        if (!rx_enable) begin
            lr_prev_valid_n = 1'b0;
            locked_n        = 1'b0;
            bit_cnt_n       = 5'd0;
            left_ok_n       = 1'b0;
        end else if (bck_rise) begin
            lr_prev_n       = lrck_s;
            lr_prev_valid_n = 1'b1;
            if (lr_prev_valid && (lrck_s != lr_prev)) begin
                // bit_cnt is only nonzero once locked, so start-up never errors
                if ((bit_cnt != 5'd0) && (bit_cnt < 5'd16)) begin
                    fe_set = 1'b1;
                    if (!channel) begin
                        left_ok_n = 1'b0;
                    end
                end
                locked_n  = 1'b1;
                channel_n = lrck_s;
                bit_cnt_n = 5'd0;
                if (!lrck_s) begin
                    left_ok_n = 1'b0;
                end
            end else if (locked && (bit_cnt < 5'd16)) begin
                bit_cnt_n = bit_cnt + 5'd1;
                if (!channel) begin
                    left_sr_n = {left_sr[14:0], sdin_s};
                    if (bit_cnt == 5'd15) begin
                        left_ok_n = 1'b1;
                    end
                end else begin
                    right_sr_n = {right_sr[14:0], sdin_s};
                    if ((bit_cnt == 5'd15) && left_ok) begin
                        word_load = 1'b1;
                    end
                end
            end
        end
    end

    assign word        = {left_sr, right_sr[14:0], sdin_s};
    assign overrun_set = word_load & out_valid & ~out_ready;

    // Capture state register.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            lr_prev       <= 1'b0;
            lr_prev_valid <= 1'b0;
            locked        <= 1'b0;
            channel       <= 1'b0;
            bit_cnt       <= 5'd0;
            left_ok       <= 1'b0;
            left_sr       <= 16'd0;
            right_sr      <= 16'd0;
        end else begin
            lr_prev       <= lr_prev_n;
            lr_prev_valid <= lr_prev_valid_n;
            locked        <= locked_n;
            channel       <= channel_n;
            bit_cnt       <= bit_cnt_n;
            left_ok       <= left_ok_n;
            left_sr       <= left_sr_n;
            right_sr      <= right_sr_n;
        end
    end

    // Output word register, valid flag and one-cycle status pulses.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            out_data    <= 32'd0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (word_load) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            overrun     <= overrun_set;
            framing_err <= fe_set;
        end
    end

`ifdef I2S_RECEIVER_OVERRUN_COUNT_EN
    logic [7:0] ovr_cnt;

    // Saturating overrun counter, cleared only by reset.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            ovr_cnt <= 8'd0;
        end else if (overrun_set && (ovr_cnt != 8'hFF)) begin
            ovr_cnt <= ovr_cnt + 8'd1;
        end
    end

    assign overrun_count = ovr_cnt;
`else
    assign overrun_count = 8'd0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: drives I2S frames into i2s_receiver and compares the words,
// overrun and framing pulses against expectations built from frame content.
module tb_i2s_receiver;

  localparam int HALF_BCK = 177;

  logic        in_clk = 1'b0;
  logic        reset;
  logic        rx_enable;
  logic        bck;
  logic        lrck;
  logic        sdin;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        framing_err;
  logic [7:0]  overrun_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  int ovr_cycles = 0;
  int fe_cycles = 0;
  int valid_rises = 0;
  logic valid_d = 1'b0;
  bit rnd_ready = 1'b0;

  // clock / reset block
  always #10 in_clk = ~in_clk;

  i2s_receiver #(.SYNC_STAGES(2)) dut (
    .in_clk        (in_clk),
    .reset         (reset),
    .rx_enable     (rx_enable),
    .bck           (bck),
    .lrck          (lrck),
    .sdin          (sdin),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun       (overrun),
    .framing_err   (framing_err),
    .overrun_count (overrun_count)
  );

  // monitor: records accepted words and counts status pulses
  always @(negedge in_clk) begin
    if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
    if (out_valid === 1'b1 && out_ready === 1'b1) acc_q.push_back(out_data);
    if (overrun === 1'b1) ovr_cycles++;
    if (framing_err === 1'b1) fe_cycles++;
    if (out_valid === 1'b1 && valid_d !== 1'b1) valid_rises++;
    valid_d = out_valid;
  end

  // driver tasks
  task automatic drive_bit(input logic lr, input logic d);
    lrck = lr;
    sdin = d;
    #HALF_BCK bck = 1'b1;
    #HALF_BCK bck = 1'b0;
  endtask

  // delay slot, nbits data bits MSB first, padding only for a full channel
  task automatic send_channel(input logic lr, input logic [15:0] data, input int nbits);
    drive_bit(lr, 1'($urandom_range(0, 1)));
    for (int i = 0; i < nbits; i++) drive_bit(lr, data[15-i]);
    if (nbits == 16) begin
      for (int i = 0; i < 15; i++) drive_bit(lr, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_channel(1'b0, w[31:16], 16);
    send_channel(1'b1, w[15:0], 16);
  endtask

  task automatic lead_in(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic set_ready(input logic v);
    @(posedge in_clk);
    #1 out_ready = v;
  endtask

  task automatic set_enable(input logic v);
    @(posedge in_clk);
    #1 rx_enable = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge in_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(5);
    @(negedge in_clk);
    checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL reset_out_data: got %h expected %h", out_data, 32'd0); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (framing_err !== 1'b0) begin failures++; $display("FAIL reset_framing_err: got %b expected 0", framing_err); end
    checks++; if (overrun_count !== 8'd0) begin failures++; $display("FAIL reset_overrun_count: got %0d expected 0", overrun_count); end
    reset = 1'b0;
    idle(3);
  endtask

  task automatic test_single_frame();
    int v0 = valid_rises;
    int f0 = fe_cycles;
    acc_q.delete(); exp_q.delete();
    lead_in(2);
    send_frame(32'hD9999991);
    exp_q.push_back(32'hD9999991);
    idle(20);
    checks++; if (valid_rises - v0 !== 1) begin failures++; $display("FAIL single_valid_pulses: got %0d expected 1", valid_rises - v0); end
    checks++; if (fe_cycles - f0 !== 0) begin failures++; $display("FAIL single_framing: got %0d expected 0", fe_cycles - f0); end
    checks++;
    if (acc_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL single_word_count: got %0d expected %0d", acc_q.size(), exp_q.size());
    end else if (acc_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL single_word: got %h expected %h", acc_q[0], exp_q[0]);
    end
  endtask

  task automatic test_overrun();
    int o0 = ovr_cycles;
    int v0 = valid_rises;
    logic [7:0] exp_cnt;
    acc_q.delete(); exp_q.delete();
`ifdef I2S_RECEIVER_OVERRUN_COUNT_EN
    exp_cnt = 8'd1;
`else
    exp_cnt = 8'd0;
`endif
    set_ready(1'b0);
    lead_in(2);
    send_frame(32'hD9999991);
    send_frame(32'h99999993);
    idle(10);
    @(negedge in_clk);
    checks++; if (ovr_cycles - o0 !== 1) begin failures++; $display("FAIL overrun_pulses: got %0d expected 1", ovr_cycles - o0); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL overrun_valid_held: got %b expected 1", out_valid); end
    checks++; if (out_data !== 32'h99999993) begin failures++; $display("FAIL overrun_data: got %h expected %h", out_data, 32'h99999993); end
    checks++; if (overrun_count !== exp_cnt) begin failures++; $display("FAIL overrun_count: got %0d expected %0d", overrun_count, exp_cnt); end
    checks++; if (acc_q.size() !== 0) begin failures++; $display("FAIL overrun_no_accept: got %0d expected 0", acc_q.size()); end
    set_ready(1'b1);
    exp_q.push_back(32'h99999993);
    idle(5);
    @(negedge in_clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL overrun_drain_valid: got %b expected 0", out_valid); end
    checks++;
    if (acc_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL overrun_drain_count: got %0d expected %0d", acc_q.size(), exp_q.size());
    end else if (acc_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL overrun_drain_word: got %h expected %h", acc_q[0], exp_q[0]);
    end
    checks++; if (valid_rises - v0 !== 1) begin failures++; $display("FAIL overrun_valid_rises: got %0d expected 1", valid_rises - v0); end
  endtask

  task automatic test_framing();
    int f0 = fe_cycles;
    logic [31:0] bad;
    logic [31:0] good;
    acc_q.delete(); exp_q.delete();
    bad = $urandom;
    good = $urandom;
    lead_in(2);
    send_channel(1'b0, bad[31:16], 10);
    send_channel(1'b1, bad[15:0], 16);
    send_frame(good);
    exp_q.push_back(good);
    idle(20);
    checks++; if (fe_cycles - f0 !== 1) begin failures++; $display("FAIL framing_pulses: got %0d expected 1", fe_cycles - f0); end
    checks++;
    if (acc_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL framing_word_count: got %0d expected %0d", acc_q.size(), exp_q.size());
    end else if (acc_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL framing_next_word: got %h expected %h", acc_q[0], exp_q[0]);
    end
  endtask

  task automatic test_mid_right_start();
    int f0;
    logic [31:0] w1;
    logic [31:0] w2;
    acc_q.delete(); exp_q.delete();
    w1 = $urandom;
    w2 = $urandom;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    f0 = fe_cycles;
    for (int i = 0; i < 20; i++) drive_bit(1'b1, 1'($urandom_range(0, 1)));
    send_frame(w1);
    send_frame(w2);
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    idle(20);
    checks++; if (fe_cycles - f0 !== 0) begin failures++; $display("FAIL midright_framing: got %0d expected 0", fe_cycles - f0); end
    checks++;
    if (acc_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL midright_word_count: got %0d expected %0d", acc_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (acc_q[i] !== exp_q[i]) begin failures++; $display("FAIL midright_word%0d: got %h expected %h", i, acc_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int f0;
    logic [15:0] left_w;
    acc_q.delete(); exp_q.delete();
    left_w = 16'h1234;
    lead_in(2);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'b0, left_w[15-i]);
    @(negedge in_clk);
    reset = 1'b1;
    idle(3);
    @(negedge in_clk);
    checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL midreset_out_data: got %h expected %h", out_data, 32'd0); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midreset_overrun: got %b expected 0", overrun); end
    checks++; if (framing_err !== 1'b0) begin failures++; $display("FAIL midreset_framing_err: got %b expected 0", framing_err); end
    checks++; if (overrun_count !== 8'd0) begin failures++; $display("FAIL midreset_overrun_count: got %0d expected 0", overrun_count); end
    reset = 1'b0;
    f0 = fe_cycles;
    for (int i = 8; i < 16; i++) drive_bit(1'b0, left_w[15-i]);
    for (int i = 0; i < 15; i++) drive_bit(1'b0, 1'b0);
    send_channel(1'b1, 16'h5678, 16);
    send_frame(32'hCAFEBABE);
    exp_q.push_back(32'hCAFEBABE);
    idle(20);
    checks++; if (fe_cycles - f0 !== 0) begin failures++; $display("FAIL midreset_framing: got %0d expected 0", fe_cycles - f0); end
    checks++;
    if (acc_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL midreset_word_count: got %0d expected %0d", acc_q.size(), exp_q.size());
    end else if (acc_q[0] !== exp_q[0]) begin
      failures++; $display("FAIL midreset_word: got %h expected %h", acc_q[0], exp_q[0]);
    end
  endtask

  task automatic test_rx_disable();
    int v0 = valid_rises;
    logic [31:0] w0;
    logic [31:0] w;
    acc_q.delete(); exp_q.delete();
    w0 = $urandom;
    w = $urandom;
    set_ready(1'b0);
    lead_in(2);
    send_frame(w0);
    exp_q.push_back(w0);
    set_enable(1'b0);
    set_ready(1'b1);
    idle(5);
    checks++; if (acc_q.size() !== 1) begin failures++; $display("FAIL disable_drain: got %0d expected 1", acc_q.size()); end
    send_frame($urandom);
    send_frame($urandom);
    idle(10);
    checks++; if (valid_rises - v0 !== 1) begin failures++; $display("FAIL disable_no_words: got %0d expected 1", valid_rises - v0); end
    set_enable(1'b1);
    lead_in(3);
    send_frame(w);
    exp_q.push_back(w);
    idle(20);
    checks++;
    if (acc_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL disable_word_count: got %0d expected %0d", acc_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (acc_q[i] !== exp_q[i]) begin failures++; $display("FAIL disable_word%0d: got %h expected %h", i, acc_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random_frames();
    int f0 = fe_cycles;
    int o0 = ovr_cycles;
    int fe_exp = 0;
    int nb;
    logic [31:0] w;
    acc_q.delete(); exp_q.delete();
    rnd_ready = 1'b1;
    lead_in(2);
    for (int f = 0; f < 12; f++) begin
      w = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        nb = $urandom_range(1, 15);
        send_channel(1'b0, w[31:16], nb);
        send_channel(1'b1, w[15:0], 16);
        fe_exp++;
      end else begin
        send_frame(w);
        exp_q.push_back(w);
      end
    end
    idle(20);
    rnd_ready = 1'b0;
    set_ready(1'b1);
    idle(5);
    checks++; if (fe_cycles - f0 !== fe_exp) begin failures++; $display("FAIL random_framing: got %0d expected %0d", fe_cycles - f0, fe_exp); end
    checks++; if (ovr_cycles - o0 !== 0) begin failures++; $display("FAIL random_overrun: got %0d expected 0", ovr_cycles - o0); end
    checks++;
    if (acc_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL random_word_count: got %0d expected %0d", acc_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (acc_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_word%0d: got %h expected %h", i, acc_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_enable = 1'b1;
    bck = 1'b0;
    lrck = 1'b1;
    sdin = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_single_frame();
    test_overrun();
    test_framing();
    test_mid_right_start();
    test_reset_mid_word();
    test_rx_disable();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
